usb_in_ep_arbiter: RTL and testbench

USB_IN_EP_ARBITER -- requirements
Module: usb_in_ep_arbiter

---
 rtl/usb_in_ep_arbiter_if.sv | 42 ++++
 rtl/usb_in_ep_arbiter.sv | 140 ++++++++++++++
 tb/tb_usb_in_ep_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_in_ep_arbiter_if.sv
// Bundle of the per-endpoint IN request/data signals and the shared IN-buffer
// handshake. The arbiter connects through the slave modport; endpoints/buffer use master.
interface usb_in_ep_arbiter_if #(
  parameter int NUM_EP = 4
);
  localparam int SEL_W = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;

  logic [NUM_EP-1:0]   ep_req;
  logic [NUM_EP-1:0]   ep_grant;
  logic [NUM_EP-1:0]   ep_data_put;
  logic [8*NUM_EP-1:0] ep_data;
  logic [NUM_EP-1:0]   ep_data_done;
  logic [NUM_EP-1:0]   ep_stall;
  logic [NUM_EP-1:0]   ep_acked;

  logic                in_ep_req;
  logic                in_ep_grant;
  logic                in_ep_data_put;
  logic [7:0]          in_ep_data;
  logic                in_ep_data_done;
  logic                in_ep_stall;
  logic                in_ep_acked;

  logic [SEL_W-1:0]    ep_sel;
  logic                timeout;

  modport slave (
    input  ep_req, ep_data_put, ep_data, ep_data_done, ep_stall,
    input  in_ep_grant, in_ep_acked,
    output ep_grant, ep_acked,
    output in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
    output ep_sel, timeout
  );

  modport master (
    output ep_req, ep_data_put, ep_data, ep_data_done, ep_stall,
    output in_ep_grant, in_ep_acked,
    input  ep_grant, ep_acked,
    input  in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
    input  ep_sel, timeout
  );
endinterface

// File: rtl/usb_in_ep_arbiter.sv
// Round-robin arbiter sharing one USB IN buffer between NUM_EP endpoints.
// Define USB_ARB_TIMEOUT_EN to add a watchdog that releases a stuck owner.
module usb_in_ep_arbiter #(
  parameter int NUM_EP         = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               reset_n,
  usb_in_ep_arbiter_if.slave bus
);
  localparam int SEL_W = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_ACK} state_t;

  state_t           state, state_next;
  logic [SEL_W-1:0] ep_sel_q, sel_next;
  logic [SEL_W-1:0] last_owner, last_next;
  logic [SEL_W-1:0] winner, scan_idx;
  logic             any_req;
  logic [NUM_EP-1:0] sel_onehot;
  logic             owner_req, owner_put, owner_done, owner_stall;
  logic [7:0]       owner_data;

  // Walk offsets downward so the nearest set request after last_owner wins.
  always_comb begin
    winner   = '0;
    any_req  = 1'b0;
    scan_idx = '0;
    for (int i = NUM_EP; i >= 1; i--) begin
      scan_idx = SEL_W'((int'(last_owner) + i) % NUM_EP);
      if (bus.ep_req[scan_idx]) begin
        winner  = scan_idx;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    sel_onehot  = '0;
    owner_req   = 1'b0;
    owner_put   = 1'b0;
    owner_done  = 1'b0;
    owner_stall = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (SEL_W'(i) == ep_sel_q) begin
        sel_onehot[i] = 1'b1;
        owner_req     = bus.ep_req[i];
        owner_put     = bus.ep_data_put[i];
        owner_done    = bus.ep_data_done[i];
        owner_stall   = bus.ep_stall[i];
        owner_data    = bus.ep_data[8*i +: 8];
      end
    end
  end

`ifdef USB_ARB_TIMEOUT_EN
  localparam logic [15:0] LIMIT_M1 = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_cnt;
  logic        timeout_q;
  logic        activity;
  logic        expire;

  assign activity = bus.in_ep_data_put | ((state == WAIT_ACK) & bus.in_ep_acked);
  assign expire   = (state != IDLE) & ~activity & (wd_cnt == LIMIT_M1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire;
      if ((state_next != state) || activity || (state == IDLE)) wd_cnt <= '0;
      else                                                      wd_cnt <= wd_cnt + 16'd1;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    sel_next   = ep_sel_q;
    last_next  = last_owner;
    unique case (state)
      IDLE: if (any_req) begin
        state_next = GRANT;
        sel_next   = winner;
      end
      GRANT: begin
        if (owner_done)                     state_next = WAIT_ACK;
        else if (owner_stall || !owner_req) state_next = IDLE;
      end
      WAIT_ACK: if (bus.in_ep_acked) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
`ifdef USB_ARB_TIMEOUT_EN
    if (expire) state_next = IDLE;
`endif
    if ((state != IDLE) && (state_next == IDLE)) last_next = ep_sel_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking here so every register samples pre-edge values regardless of order.
    if (!reset_n) begin
      state      <= IDLE;
      ep_sel_q   <= '0;
      last_owner <= SEL_W'(NUM_EP - 1);
    end else begin
      state      <= state_next;
      ep_sel_q   <= sel_next;
      last_owner <= last_next;
    end
  end

  // Outputs decode from state, so reset clears them without waiting for an edge.
  always_comb begin
    bus.ep_grant        = '0;
    bus.ep_acked        = '0;
    bus.in_ep_req       = (state != IDLE);
    bus.in_ep_data_put  = 1'b0;
    bus.in_ep_data      = '0;
    bus.in_ep_data_done = 1'b0;
    bus.in_ep_stall     = 1'b0;
    if (state == GRANT && bus.in_ep_grant) begin
      bus.ep_grant        = sel_onehot;
      bus.in_ep_data_put  = owner_put;
      bus.in_ep_data      = owner_data;
      bus.in_ep_data_done = owner_done;
      bus.in_ep_stall     = owner_stall;
    end
    if (state == WAIT_ACK && bus.in_ep_acked) bus.ep_acked = sel_onehot;
  end

  assign bus.ep_sel = ep_sel_q;
endmodule

// File: tb/tb_usb_in_ep_arbiter.sv
// Directed bench for usb_in_ep_arbiter (NUM_EP=4, TIMEOUT_CYCLES=16); the
// timeout scenario follows whether USB_ARB_TIMEOUT_EN is defined.
module tb_usb_in_ep_arbiter;
  localparam int NUM_EP = 4;
  localparam int TO     = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  usb_in_ep_arbiter_if #(.NUM_EP(NUM_EP)) bus ();

  usb_in_ep_arbiter #(.NUM_EP(NUM_EP), .TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.ep_req       = '0;
    bus.ep_data_put  = '0;
    bus.ep_data      = '0;
    bus.ep_data_done = '0;
    bus.ep_stall     = '0;
    bus.in_ep_grant  = 1'b1;
    bus.in_ep_acked  = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    bus.ep_req = 4'b1111;
    settle();
    checks++; if (bus.in_ep_req !== 1'b0) begin failures++; $display("FAIL reset_in_ep_req: got %b want 0", bus.in_ep_req); end
    checks++; if (bus.ep_grant !== 4'b0000) begin failures++; $display("FAIL reset_ep_grant: got %b want 0000", bus.ep_grant); end
    checks++; if (bus.ep_sel !== 2'd0) begin failures++; $display("FAIL reset_ep_sel: got %0d want 0", bus.ep_sel); end
    checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b want 0", bus.timeout); end
    do_reset();
  endtask

  task automatic test_basic_packet();
    bus.ep_req = 4'b0001;
    settle();
    checks++; if (bus.in_ep_req !== 1'b0) begin failures++; $display("FAIL basic_idle: got in_ep_req=%b want 0", bus.in_ep_req); end
    tick();
    checks++; if (bus.ep_grant !== 4'b0001) begin failures++; $display("FAIL basic_grant: got %b want 0001", bus.ep_grant); end
    checks++; if (bus.in_ep_req !== 1'b1) begin failures++; $display("FAIL basic_in_req: got %b want 1", bus.in_ep_req); end
    bus.ep_data_put = 4'b0001;
    bus.ep_data = 32'h0000_00A1;
    settle();
    checks++; if ({bus.in_ep_data_put, bus.in_ep_data} !== 9'h1A1) begin failures++; $display("FAIL basic_put_a1: got %b/%h want 1/a1", bus.in_ep_data_put, bus.in_ep_data); end
    tick();
    bus.ep_data = 32'h0000_00A2;
    settle();
    checks++; if ({bus.in_ep_data_put, bus.in_ep_data} !== 9'h1A2) begin failures++; $display("FAIL basic_put_a2: got %b/%h want 1/a2", bus.in_ep_data_put, bus.in_ep_data); end
    tick();
    bus.ep_data = 32'h0000_00A3;
    settle();
    checks++; if ({bus.in_ep_data_put, bus.in_ep_data} !== 9'h1A3) begin failures++; $display("FAIL basic_put_a3: got %b/%h want 1/a3", bus.in_ep_data_put, bus.in_ep_data); end
    checks++; if (bus.in_ep_data_done !== 1'b0) begin failures++; $display("FAIL basic_early_done: got %b want 0", bus.in_ep_data_done); end
    tick();
    bus.ep_data_put = '0;
    bus.ep_data = '0;
    bus.ep_data_done = 4'b0001;
    settle();
    checks++; if (bus.in_ep_data_done !== 1'b1) begin failures++; $display("FAIL basic_done: got %b want 1", bus.in_ep_data_done); end
    tick();
    bus.ep_data_done = '0;
    bus.ep_req = '0;
    settle();
    checks++; if ({bus.in_ep_req, bus.ep_grant, bus.in_ep_data_done} !== 6'b1_0000_0) begin failures++; $display("FAIL basic_wait_ack: got req/grant/done=%b want 1_0000_0", {bus.in_ep_req, bus.ep_grant, bus.in_ep_data_done}); end
    checks++; if (bus.ep_acked !== 4'b0000) begin failures++; $display("FAIL basic_early_ack: got %b want 0000", bus.ep_acked); end
    tick();
    bus.in_ep_acked = 1'b1;
    settle();
    checks++; if (bus.ep_acked !== 4'b0001) begin failures++; $display("FAIL basic_acked: got %b want 0001", bus.ep_acked); end
    tick();
    bus.in_ep_acked = 1'b0;
    settle();
    checks++; if ({bus.in_ep_req, bus.ep_acked} !== 5'b0_0000) begin failures++; $display("FAIL basic_back_idle: got req/acked=%b want 0_0000", {bus.in_ep_req, bus.ep_acked}); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oh;
    do_reset();
    bus.ep_req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      exp_oh = 4'b0001 << k;
      settle();
      checks++; if ({bus.in_ep_req, bus.ep_grant} !== 5'b0_0000) begin failures++; $display("FAIL rr_idle_gap%0d: got req/grant=%b want 0_0000", k, {bus.in_ep_req, bus.ep_grant}); end
      tick();
      checks++; if (bus.ep_sel !== 2'(k)) begin failures++; $display("FAIL rr_owner%0d: got %0d want %0d", k, bus.ep_sel, k); end
      checks++; if (bus.ep_grant !== exp_oh) begin failures++; $display("FAIL rr_grant%0d: got %b want %b", k, bus.ep_grant, exp_oh); end
      bus.ep_data_done = exp_oh;
      tick();
      bus.ep_data_done = '0;
      bus.in_ep_acked = 1'b1;
      settle();
      checks++; if (bus.ep_acked !== exp_oh) begin failures++; $display("FAIL rr_acked%0d: got %b want %b", k, bus.ep_acked, exp_oh); end
      tick();
      bus.in_ep_acked = 1'b0;
    end
    bus.ep_req = '0;
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    bus.ep_req = 4'b0100;
    tick();
    checks++; if (bus.ep_sel !== 2'd2) begin failures++; $display("FAIL stall_owner: got %0d want 2", bus.ep_sel); end
    bus.ep_stall = 4'b0100;
    bus.ep_req = 4'b1100;
    settle();
    checks++; if (bus.in_ep_stall !== 1'b1) begin failures++; $display("FAIL stall_fwd: got %b want 1", bus.in_ep_stall); end
    tick();
    bus.ep_stall = '0;
    settle();
    checks++; if ({bus.in_ep_req, bus.in_ep_stall} !== 2'b00) begin failures++; $display("FAIL stall_idle: got req/stall=%b want 00", {bus.in_ep_req, bus.in_ep_stall}); end
    tick();
    checks++; if ({bus.ep_sel, bus.ep_grant} !== {2'd3, 4'b1000}) begin failures++; $display("FAIL stall_next_owner: got sel=%0d grant=%b want 3/1000", bus.ep_sel, bus.ep_grant); end
    bus.ep_req = '0;
    tick();
  endtask

  task automatic test_done_with_req_drop();
    bus.ep_req = 4'b0010;
    tick();
    checks++; if (bus.ep_grant !== 4'b0010) begin failures++; $display("FAIL drop_grant: got %b want 0010", bus.ep_grant); end
    bus.ep_data_put  = 4'b0001;
    bus.ep_data      = 32'h0000_0055;
    bus.ep_data_done = 4'b0001;
    bus.ep_stall     = 4'b0001;
    settle();
    checks++; if ({bus.in_ep_data_put, bus.in_ep_data, bus.in_ep_data_done, bus.in_ep_stall} !== 11'd0) begin failures++; $display("FAIL nonowner_fwd: got put/data/done/stall=%b/%h/%b/%b want all 0", bus.in_ep_data_put, bus.in_ep_data, bus.in_ep_data_done, bus.in_ep_stall); end
    tick();
    clear_inputs();
    bus.ep_req = 4'b0010;
    settle();
    checks++; if (bus.ep_grant !== 4'b0010) begin failures++; $display("FAIL nonowner_kept: got %b want 0010", bus.ep_grant); end
    bus.ep_data_done = 4'b0010;
    bus.ep_req = 4'b0000;
    tick();
    bus.ep_data_done = '0;
    settle();
    checks++; if ({bus.in_ep_req, bus.ep_grant} !== 5'b1_0000) begin failures++; $display("FAIL drop_wait_ack: got req/grant=%b want 1_0000", {bus.in_ep_req, bus.ep_grant}); end
    bus.in_ep_acked = 1'b1;
    tick();
    bus.in_ep_acked = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    bus.ep_req = 4'b0001;
    tick();
    bus.ep_data_put = 4'b0001;
    bus.ep_data = 32'h0000_00C3;
    bus.ep_data_done = 4'b0001;
    settle();
    checks++; if (bus.in_ep_data_put !== 1'b1) begin failures++; $display("FAIL midrst_pre_put: got %b want 1", bus.in_ep_data_put); end
    reset_n = 1'b0;
    settle();
    checks++; if ({bus.ep_grant, bus.ep_acked, bus.in_ep_req, bus.in_ep_data_put, bus.in_ep_data, bus.in_ep_data_done, bus.in_ep_stall, bus.ep_sel, bus.timeout} !== '0) begin failures++; $display("FAIL midrst_outputs: got grant=%b req=%b put=%b data=%h done=%b sel=%0d want all 0", bus.ep_grant, bus.in_ep_req, bus.in_ep_data_put, bus.in_ep_data, bus.in_ep_data_done, bus.ep_sel); end
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus.ep_req = 4'b1010;
    tick();
    checks++; if ({bus.ep_sel, bus.ep_grant} !== {2'd1, 4'b0010}) begin failures++; $display("FAIL midrst_winner: got sel=%0d grant=%b want 1/0010", bus.ep_sel, bus.ep_grant); end
    bus.ep_req = '0;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    bus.ep_req = 4'b0001;
    tick();
    bus.ep_data_done = 4'b0001;
    tick();
    bus.ep_data_done = '0;
    bus.ep_req = '0;
`ifdef USB_ARB_TIMEOUT_EN
    for (int i = 1; i < TO; i++) begin
      tick();
      checks++; if ({bus.in_ep_req, bus.timeout} !== 2'b10) begin failures++; $display("FAIL to_wait%0d: got req/timeout=%b want 10", i, {bus.in_ep_req, bus.timeout}); end
    end
    tick();
    checks++; if ({bus.in_ep_req, bus.timeout, bus.ep_acked} !== 6'b0_1_0000) begin failures++; $display("FAIL to_fire: got req/timeout/acked=%b want 0_1_0000", {bus.in_ep_req, bus.timeout, bus.ep_acked}); end
    tick();
    checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL to_pulse_width: got %b want 0", bus.timeout); end
`else
    for (int i = 1; i <= 3 * TO; i++) begin
      tick();
      checks++; if ({bus.in_ep_req, bus.timeout} !== 2'b10) begin failures++; $display("FAIL hold_wait%0d: got req/timeout=%b want 10", i, {bus.in_ep_req, bus.timeout}); end
    end
    bus.in_ep_acked = 1'b1;
    tick();
    bus.in_ep_acked = 1'b0;
    checks++; if (bus.in_ep_req !== 1'b0) begin failures++; $display("FAIL hold_release: got %b want 0", bus.in_ep_req); end
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_basic_packet();
    test_round_robin();
    test_stall();
    test_done_with_req_drop();
    test_reset_mid_packet();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
